// File: rtl/mem_rw_arbiter.sv
// mem_rw_arbiter: shares one single-port synchronous memory between a write
// requester and a read requester.
//   - Each requester holds a level request until it receives a one-cycle ack.
//   - When both contend, grants alternate between them.
//   - No grant is issued during a hold-off window after reset.
//   - Per-requester wait counters raise sticky starvation flags.
// Ports:
//   clk, rst                          clock, async active-high reset
//   wr_req/wr_addr/wr_data -> wr_ack  write requester handshake
//   rd_req/rd_addr -> rd_ack/rd_data  read requester handshake
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (registered)
//   mem_rdata                         memory read data, valid in last access cycle
//   wr_starve/rd_starve               sticky starvation flags
module mem_rw_arbiter #(
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned LAT     = 2,
    parameter int unsigned HOLDOFF = 2,
    parameter int unsigned TIMEOUT = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          wr_starve,
    output logic          rd_starve
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic [HW-1:0] holdoff_q, holdoff_d;
    logic [TW-1:0] wr_wait_q, wr_wait_d;
    logic [TW-1:0] rd_wait_q, rd_wait_d;
    logic          last_grant_q, last_grant_d;   // 1 = write, 0 = read
    logic          wr_ack_q, wr_ack_d;
    logic          rd_ack_q, rd_ack_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          wr_starve_q, wr_starve_d;
    logic          rd_starve_q, rd_starve_d;

    logic          holdoff_done_c;
    logic          grant_wr_c, grant_rd_c;
    logic          wr_owner_c, rd_owner_c;

    // Next-state, grant and datapath logic
    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        holdoff_d    = holdoff_q;
        last_grant_d = last_grant_q;
        wr_ack_d     = 1'b0;
        rd_ack_d     = 1'b0;
        rd_data_d    = rd_data_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        grant_wr_c   = 1'b0;
        grant_rd_c   = 1'b0;

        holdoff_done_c = (holdoff_q == HW'(HOLDOFF));
        if (!holdoff_done_c) begin
            holdoff_d = holdoff_q + HW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (holdoff_done_c) begin
                    if (wr_req && rd_req) begin
                        // Contended: the side that did not win last time goes first
                        grant_wr_c = !last_grant_q;
                        grant_rd_c = last_grant_q;
                    end else begin
                        grant_wr_c = wr_req;
                        grant_rd_c = rd_req;
                    end
                end
                if (grant_wr_c || grant_rd_c) begin
                    state_d      = S_ACCESS;
                    acc_cnt_d    = CW'(LAT - 1);
                    last_grant_d = grant_wr_c;
                    mem_en_d     = 1'b1;
                    mem_we_d     = grant_wr_c;
                    mem_addr_d   = grant_wr_c ? wr_addr : rd_addr;
                    if (grant_wr_c) begin
                        mem_wdata_d = wr_data;
                    end
                end
            end
            S_ACCESS: begin
                if (acc_cnt_q == CW'(0)) begin
                    state_d  = S_ACK;
                    mem_en_d = 1'b0;
                    if (mem_we_q) begin
                        wr_ack_d = 1'b1;
                    end else begin
                        rd_ack_d  = 1'b1;
                        rd_data_d = mem_rdata;
                    end
                end else begin
                    acc_cnt_d = acc_cnt_q - CW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    // Wait counters: count while requesting, unserved, and past hold-off
    always_comb begin
        wr_owner_c = (state_q != S_IDLE) && mem_we_q;
        rd_owner_c = (state_q != S_IDLE) && !mem_we_q;
        wr_wait_d  = wr_wait_q;
        rd_wait_d  = rd_wait_q;

        if (grant_wr_c) begin
            wr_wait_d = '0;
        end else if (wr_req && holdoff_done_c && !wr_owner_c && (wr_wait_q != TW'(TIMEOUT))) begin
            wr_wait_d = wr_wait_q + TW'(1);
        end

        if (grant_rd_c) begin
            rd_wait_d = '0;
        end else if (rd_req && holdoff_done_c && !rd_owner_c && (rd_wait_q != TW'(TIMEOUT))) begin
            rd_wait_d = rd_wait_q + TW'(1);
        end

        wr_starve_d = wr_starve_q || (wr_wait_d == TW'(TIMEOUT));
        rd_starve_d = rd_starve_q || (rd_wait_d == TW'(TIMEOUT));
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_cnt_q    <= '0;
            holdoff_q    <= '0;
            wr_wait_q    <= '0;
            rd_wait_q    <= '0;
            last_grant_q <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_data_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wr_starve_q  <= 1'b0;
            rd_starve_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            holdoff_q    <= holdoff_d;
            wr_wait_q    <= wr_wait_d;
            rd_wait_q    <= rd_wait_d;
            last_grant_q <= last_grant_d;
            wr_ack_q     <= wr_ack_d;
            rd_ack_q     <= rd_ack_d;
            rd_data_q    <= rd_data_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wr_starve_q  <= wr_starve_d;
            rd_starve_q  <= rd_starve_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_starve = wr_starve_q;
    assign rd_starve = rd_starve_q;

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Testbench for mem_rw_arbiter: table-driven cycle vectors plus directed
// sequences for contention, reset mid-access and starvation.
module tb_mem_rw_arbiter;

    logic       clk;
    logic       rst;

    // Default-parameter instance
    logic       wr_req, rd_req, wr_ack, rd_ack;
    logic [3:0] wr_addr, rd_addr, mem_addr;
    logic [7:0] wr_data, rd_data, mem_wdata, mem_rdata;
    logic       mem_en, mem_we, wr_starve, rd_starve;

    // Long-latency instance for the starvation case
    logic       sv_wr_req, sv_rd_req, sv_wr_ack, sv_rd_ack;
    logic [3:0] sv_wr_addr, sv_rd_addr, sv_mem_addr;
    logic [7:0] sv_wr_data, sv_rd_data, sv_mem_wdata, sv_mem_rdata;
    logic       sv_mem_en, sv_mem_we, sv_wr_starve, sv_rd_starve;

    int tests;
    int fails;

    mem_rw_arbiter #(.AW(4), .DW(8), .LAT(2), .HOLDOFF(2), .TIMEOUT(10)) u_dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wr_starve(wr_starve), .rd_starve(rd_starve)
    );

    mem_rw_arbiter #(.AW(4), .DW(8), .LAT(12), .HOLDOFF(2), .TIMEOUT(10)) u_sv (
        .clk(clk), .rst(rst),
        .wr_req(sv_wr_req), .wr_addr(sv_wr_addr), .wr_data(sv_wr_data), .wr_ack(sv_wr_ack),
        .rd_req(sv_rd_req), .rd_addr(sv_rd_addr), .rd_ack(sv_rd_ack), .rd_data(sv_rd_data),
        .mem_en(sv_mem_en), .mem_we(sv_mem_we), .mem_addr(sv_mem_addr), .mem_wdata(sv_mem_wdata),
        .mem_rdata(sv_mem_rdata), .wr_starve(sv_wr_starve), .rd_starve(sv_rd_starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wq;
        logic [3:0]  wa;
        logic [7:0]  wd;
        logic        rq;
        logic [3:0]  ra;
        logic [7:0]  md;
        logic [23:0] exp;   // {en, we, addr, wdata, wack, rack, rd_data}
    } vec_t;

    function automatic vec_t mkv(input logic wq, input logic [3:0] wa, input logic [7:0] wd,
                                 input logic rq, input logic [3:0] ra, input logic [7:0] md,
                                 input logic [23:0] exp);
        vec_t v;
        v.wq = wq; v.wa = wa; v.wd = wd; v.rq = rq; v.ra = ra; v.md = md; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    vec_t vecs[11];

    initial begin
        logic [23:0] act;
        logic        prev_en;
        logic        ok;
        int          edge_n;
        int          bad;
        int          wack_n, rack_n;
        logic        g_we[$];
        int          g_edge[$];
        logic [5:0]  en_hist, ack_hist;

        tests = 0;
        fails = 0;

        // Reset/hold-off + single write, then single read (inputs before edge, outputs after)
        vecs[0]  = mkv(1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 8'h00, {1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00});
        vecs[1]  = mkv(1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 8'h00, {1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00});
        vecs[2]  = mkv(1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 8'h00, {1'b1, 1'b1, 4'd5, 8'hA5, 1'b0, 1'b0, 8'h00});
        vecs[3]  = mkv(1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 8'h00, {1'b1, 1'b1, 4'd5, 8'hA5, 1'b0, 1'b0, 8'h00});
        vecs[4]  = mkv(1'b1, 4'd5, 8'hA5, 1'b0, 4'd0, 8'h00, {1'b0, 1'b1, 4'd5, 8'hA5, 1'b1, 1'b0, 8'h00});
        vecs[5]  = mkv(1'b0, 4'd5, 8'hA5, 1'b0, 4'd0, 8'h00, {1'b0, 1'b1, 4'd5, 8'hA5, 1'b0, 1'b0, 8'h00});
        vecs[6]  = mkv(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h00, {1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 1'b0, 8'h00});
        vecs[7]  = mkv(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h00, {1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 1'b0, 8'h00});
        vecs[8]  = mkv(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h3C, {1'b0, 1'b0, 4'd3, 8'hA5, 1'b0, 1'b1, 8'h3C});
        vecs[9]  = mkv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'hFF, {1'b0, 1'b0, 4'd3, 8'hA5, 1'b0, 1'b0, 8'h3C});
        vecs[10] = mkv(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h77, {1'b0, 1'b0, 4'd3, 8'hA5, 1'b0, 1'b0, 8'h3C});

        rst = 1'b1;
        wr_req = vecs[0].wq; wr_addr = vecs[0].wa; wr_data = vecs[0].wd;
        rd_req = 1'b0; rd_addr = 4'd0; mem_rdata = 8'h00;
        sv_wr_req = 1'b0; sv_rd_req = 1'b0; sv_wr_addr = 4'd0; sv_rd_addr = 4'd0;
        sv_wr_data = 8'h00; sv_mem_rdata = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({mem_en, mem_we, wr_ack, rd_ack, wr_starve, rd_starve, mem_addr, mem_wdata, rd_data}),
              32'd0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            wr_req = vecs[i].wq; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_req = vecs[i].rq; rd_addr = vecs[i].ra; mem_rdata = vecs[i].md;
            @(posedge clk);
            #1;
            act = {mem_en, mem_we, mem_addr, mem_wdata, wr_ack, rd_ack, rd_data};
            check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
            @(negedge clk);
        end

        // Contention: both held for 24 edges, last grant was a read
        wr_req = 1'b1; wr_addr = 4'd9; wr_data = 8'h11;
        rd_req = 1'b1; rd_addr = 4'd2; mem_rdata = 8'h55;
        prev_en = mem_en;
        bad = 0; wack_n = 0; rack_n = 0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            #1;
            if (mem_en && !prev_en) begin
                g_we.push_back(mem_we);
                g_edge.push_back(e);
            end
            if (mem_en && (mem_addr !== (mem_we ? 4'd9 : 4'd2))) bad++;
            if (mem_en && mem_we && (mem_wdata !== 8'h11)) bad++;
            if (wr_ack) wack_n++;
            if (rd_ack) rack_n++;
            prev_en = mem_en;
        end
        @(negedge clk);
        wr_req = 1'b0; rd_req = 1'b0;
        check("cont_grant_count", 32'(g_we.size()), 32'd6);
        if (g_we.size() >= 4) begin
            check("cont_order", 32'({g_we[0], g_we[1], g_we[2], g_we[3]}), 32'(4'b1010));
            check("cont_first_edge", 32'(g_edge[0]), 32'd1);
            check("cont_spacing", 32'(g_edge[3] - g_edge[2]), 32'd4);
        end else begin
            check("cont_order_short", 32'(g_we.size()), 32'd4);
        end
        check("cont_stable_cmd", 32'(bad), 32'd0);
        check("cont_acks", 32'({wack_n[7:0], rack_n[7:0]}), 32'h0303);
        check("cont_no_starve", 32'({wr_starve, rd_starve}), 32'd0);

        // Reset asserted in the second access cycle of a write
        repeat (2) @(negedge clk);
        wr_req = 1'b1; wr_addr = 4'd7; wr_data = 8'h5A;
        @(posedge clk);
        #1;
        check("mid_grant_en", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b1, 4'd7}));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset_async",
              32'({mem_en, wr_ack, mem_we, mem_addr, mem_wdata, rd_data}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en_hist = '0; ack_hist = '0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            en_hist[e]  = mem_en;
            ack_hist[e] = wr_ack;
            if (wr_ack) begin
                @(negedge clk);
                wr_req = 1'b0;
            end
        end
        check("mid_regrant_en", 32'(en_hist), 32'(6'b001100));
        check("mid_regrant_ack", 32'(ack_hist), 32'(6'b010000));
        check("mid_addr_fresh", 32'({mem_addr, mem_wdata}), 32'({4'd7, 8'h5A}));

        // Starvation on the LAT=12 instance; write wins first contention
        @(negedge clk);
        sv_wr_req = 1'b1; sv_wr_addr = 4'd1; sv_wr_data = 8'hEE;
        sv_rd_req = 1'b1; sv_rd_addr = 4'd4; sv_mem_rdata = 8'h99;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) check("sv_first_grant_wr", 32'({sv_mem_en, sv_mem_we}), 32'(2'b11));
            if (k == 8) check("sv_starve_before", 32'(sv_rd_starve), 32'd0);
            if (k == 9) check("sv_starve_set", 32'(sv_rd_starve), 32'd1);
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (sv_wr_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("sv_wr_ack_seen", 32'(ok), 32'd1);
        @(negedge clk);
        sv_wr_req = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (sv_rd_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("sv_rd_ack_seen", 32'(ok), 32'd1);
        check("sv_rd_data", 32'(sv_rd_data), 32'h99);
        @(negedge clk);
        sv_rd_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sv_starve_sticky", 32'({sv_wr_starve, sv_rd_starve}), 32'(2'b01));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("sv_starve_cleared", 32'({sv_wr_starve, sv_rd_starve}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
